// File: rtl/ysyx_25040129_arb_pkg.sv
// rtl/ysyx_25040129_arb_pkg.sv - shared states, owner encoding and fixed AXI fields for the MMU arbiter
package ysyx_25040129_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] IFU_ARSIZE   = 3'b010;
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;

endpackage

// File: rtl/ysyx_25040129_rr_grant.sv
// rtl/ysyx_25040129_rr_grant.sv - combinational 2-way round-robin picker between IFU and LSU
module ysyx_25040129_rr_grant
    import ysyx_25040129_arb_pkg::*;
(
    input  logic       req_ifu,
    input  logic       req_lsu,
    input  logic       last_lsu,
    output logic [1:0] grant     // [0] = IFU, [1] = LSU, one-hot or zero
);

    // On a tie the unit that was not granted last wins; otherwise the sole requester wins
    always_comb begin
        grant = 2'b00;
        if (req_ifu && req_lsu) begin
            grant = last_lsu ? 2'b01 : 2'b10;
        end else if (req_lsu) begin
            grant = 2'b10;
        end else if (req_ifu) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_25040129_mmu_arbiter.sv
// rtl/ysyx_25040129_mmu_arbiter.sv - single-outstanding arbiter sharing the MMU port between IFU and LSU
module ysyx_25040129_mmu_arbiter
    import ysyx_25040129_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] satp,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] m_araddr,
    output logic [2:0]  m_arsize,
    output logic [7:0]  m_arlen,
    output logic [1:0]  m_arburst,
    output logic [31:0] m_arsatp,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic [31:0] m_awsatp,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q;
    logic        last_lsu_q;
    logic        aw_done_q, w_done_q;
    logic [31:0] addr_q, wdata_q, satp_q;
    logic [2:0]  size_q;
    logic [3:0]  wstrb_q;

    logic        lsu_wr_req, lsu_req, take;
    logic [1:0]  grant;
    logic        rd_ready;
    logic        unused_rlast;

    // Every transaction is single-beat, so rlast carries no extra information
    assign unused_rlast = m_rlast;

    // A write is only eligible once both AW and W are offered together
    assign lsu_wr_req = lsu_awvalid && lsu_wvalid;
    assign lsu_req    = lsu_wr_req || lsu_arvalid;

    ysyx_25040129_rr_grant u_rr_grant (
        .req_ifu  (ifu_arvalid),
        .req_lsu  (lsu_req),
        .last_lsu (last_lsu_q),
        .grant    (grant)
    );

    // No grant is handed out while reset is held, so an accepted request is never lost
    assign take = (state_q == ST_IDLE) && !rst && (grant != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake outputs; the non-owner always sees zeros
    always_comb begin
        state_d     = state_q;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        rd_ready    = (owner_q == OWN_IFU) ? ifu_rready : lsu_rready;
        case (state_q)
            ST_IDLE: begin
                ifu_arready = take && grant[0];
                lsu_arready = take && grant[1] && !lsu_wr_req;
                lsu_awready = take && grant[1] && lsu_wr_req;
                lsu_wready  = take && grant[1] && lsu_wr_req;
                if (take) begin
                    state_d = (grant[1] && lsu_wr_req) ? ST_WR_AW_W : ST_RD_AR;
                end
            end
            ST_RD_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_RD_R;
            end
            ST_RD_R: begin
                m_rready   = rd_ready;
                ifu_rvalid = (owner_q == OWN_IFU) && m_rvalid;
                lsu_rvalid = (owner_q == OWN_LSU) && m_rvalid;
                if (m_rvalid && rd_ready) state_d = ST_IDLE;
            end
            ST_WR_AW_W: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = ST_WR_B;
            end
            ST_WR_B: begin
                m_bready   = lsu_bready;
                lsu_bvalid = m_bvalid;
                if (m_bvalid && lsu_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Remember which write channels have already handshaked; cleared when the write phase ends
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == ST_WR_AW_W) begin
            if (state_d == ST_WR_B) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                aw_done_q <= aw_done_q || m_awready;
                w_done_q  <= w_done_q || m_wready;
            end
        end
    end

    // Capture the winning request so the MMU sees stable fields until the return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_IFU;
            last_lsu_q <= 1'b0;
            addr_q     <= 32'd0;
            size_q     <= 3'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            satp_q     <= 32'd0;
        end else if (take) begin
            owner_q    <= grant[1] ? OWN_LSU : OWN_IFU;
            last_lsu_q <= grant[1];
            satp_q     <= satp;
            if (grant[1] && lsu_wr_req) begin
                addr_q  <= lsu_awaddr;
                size_q  <= IFU_ARSIZE;
                wdata_q <= lsu_wdata;
                wstrb_q <= lsu_wstrb;
            end else if (grant[1]) begin
                addr_q <= lsu_araddr;
                size_q <= lsu_arsize;
            end else begin
                addr_q <= ifu_araddr;
                size_q <= IFU_ARSIZE;
            end
        end
    end

    assign m_araddr  = addr_q;
    assign m_arsize  = size_q;
    assign m_arlen   = ARLEN_SINGLE;
    assign m_arburst = BURST_INCR;
    assign m_arsatp  = satp_q;
    assign m_awaddr  = addr_q;
    assign m_awsatp  = satp_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;

    assign ifu_rdata = m_rdata;
    assign ifu_rresp = m_rresp;
    assign lsu_rdata = m_rdata;
    assign lsu_rresp = m_rresp;
    assign lsu_bresp = m_bresp;

endmodule

// File: tb/tb_ysyx_25040129_mmu_arbiter.sv
// tb/tb_ysyx_25040129_mmu_arbiter.sv - directed self-checking bench for the MMU arbiter
module tb_ysyx_25040129_mmu_arbiter;

    logic        clk, rst;
    logic [31:0] satp;
    logic [31:0] ifu_araddr;  logic ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp; logic ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
    logic [31:0] m_araddr;    logic [2:0] m_arsize; logic [7:0] m_arlen; logic [1:0] m_arburst;
    logic [31:0] m_arsatp;    logic m_arvalid, m_arready;
    logic [31:0] m_rdata;     logic [1:0] m_rresp; logic m_rvalid, m_rlast, m_rready;
    logic [31:0] m_awaddr, m_awsatp; logic m_awvalid, m_awready;
    logic [31:0] m_wdata;     logic [3:0] m_wstrb; logic m_wvalid, m_wready;
    logic [1:0]  m_bresp;     logic m_bvalid, m_bready;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] vld;
    assign vld = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                  lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};

    ysyx_25040129_mmu_arbiter dut (
        .clk(clk), .rst(rst), .satp(satp),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arsatp(m_arsatp), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awsatp(m_awsatp), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; satp = 32'd0;
        ifu_araddr = 32'd0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_araddr = 32'd0; lsu_arsize = 3'd0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        lsu_awaddr = 32'd0; lsu_awvalid = 1'b0; lsu_wdata = 32'd0; lsu_wstrb = 4'd0;
        lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        m_arready = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0; m_rvalid = 1'b0; m_rlast = 1'b1;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'd0; m_bvalid = 1'b0;

        // reset state
        tick(); tick();
        #1;
        chk("reset_valids", {20'd0, vld}, 32'd0);
        chk("reset_arlen_burst", {22'd0, m_arlen, m_arburst}, {22'd0, 8'd0, 2'b01});

        // tie after reset: LSU wins first
        rst = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2004; lsu_arsize = 3'b000;
        #1;
        chk("tie1_grant", {30'd0, lsu_arready, ifu_arready}, 32'h2);
        tick();
        lsu_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("tie1_ar", {m_arvalid, ifu_arready, lsu_arready, m_arsize}, {1'b1, 1'b0, 1'b0, 3'b000});
        chk("tie1_araddr", m_araddr, 32'h8000_2004);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1122_3344; lsu_rready = 1'b1;
        #1;
        chk("tie1_r_flags", {lsu_rvalid, ifu_rvalid, m_rready, ifu_arready}, {1'b1, 1'b0, 1'b1, 1'b0});
        chk("tie1_rdata", lsu_rdata, 32'h1122_3344);
        tick();
        // second tie: IFU wins
        m_rvalid = 1'b0; lsu_rready = 1'b0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2008; lsu_arsize = 3'b001;
        #1;
        chk("tie2_grant", {30'd0, lsu_arready, ifu_arready}, 32'h1);
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("tie2_araddr", m_araddr, 32'h8000_0100);
        chk("tie2_arsize", {29'd0, m_arsize}, 32'h2);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0413; ifu_rready = 1'b1;
        #1;
        chk("tie2_r_flags", {ifu_rvalid, lsu_rvalid, lsu_arready}, 3'b100);
        tick();
        // third tie: LSU again
        m_rvalid = 1'b0; ifu_rready = 1'b0; ifu_arvalid = 1'b1;
        #1;
        chk("tie3_grant", {30'd0, lsu_arready, ifu_arready}, 32'h2);
        tick();
        lsu_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("tie3_araddr", m_araddr, 32'h8000_2008);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA; lsu_rready = 1'b0;
        #1;
        chk("tie3_backpressure", {lsu_rvalid, m_rready}, 2'b10);
        tick();
        lsu_rready = 1'b1;
        #1;
        chk("tie3_rready", {lsu_rvalid, m_rready}, 2'b11);
        tick();

        // IFU read at 0x8000_0000, m_arvalid one cycle after arready
        m_rvalid = 1'b0; lsu_rready = 1'b0; ifu_araddr = 32'h8000_0000;
        #1;
        chk("ifu_grant", {30'd0, ifu_arready, m_arvalid}, 32'h2);
        tick();
        ifu_arvalid = 1'b0; ifu_araddr = 32'hFFFF_FFFF;
        #1;
        chk("ifu_ar_next", {31'd0, m_arvalid}, 32'h1);
        chk("ifu_araddr_hold", m_araddr, 32'h8000_0000);
        tick();
        m_arready = 1'b1;
        #1;
        chk("ifu_ar_wait", {31'd0, m_arvalid}, 32'h1);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0413; ifu_rready = 1'b1;
        #1;
        chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_r_flags", {ifu_rvalid, lsu_rvalid, m_arvalid}, 3'b100);
        tick();
        m_rvalid = 1'b0; ifu_rready = 1'b0;
        #1;
        chk("ifu_done_idle", {20'd0, vld}, 32'd0);

        // lone AW is not eligible; IFU served instead
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_1000; lsu_wvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0040;
        #1;
        chk("lone_aw_grant", {29'd0, lsu_awready, lsu_wready, ifu_arready}, 32'h1);
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("lone_aw_ar", {m_arvalid, m_awvalid, lsu_awready}, 3'b100);
        chk("lone_aw_araddr", m_araddr, 32'h8000_0040);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; ifu_rready = 1'b1;
        tick();
        m_rvalid = 1'b0; ifu_rready = 1'b0;

        // LSU write, write beats read, AW two cycles before W
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; satp = 32'h8008_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000;
        #1;
        chk("wr_grant", {29'd0, lsu_awready, lsu_wready, lsu_arready}, 32'h6);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_arvalid = 1'b0; lsu_wdata = 32'd0; satp = 32'd0;
        #1;
        chk("wr_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
        chk("wr_awaddr", m_awaddr, 32'h8000_1000);
        chk("wr_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", {28'd0, m_wstrb}, 32'hF);
        chk("wr_awsatp", m_awsatp, 32'h8008_0000);
        tick();
        m_awready = 1'b1;
        #1;
        chk("wr_aw_hs", {m_awvalid, m_wvalid}, 2'b11);
        tick();
        m_awready = 1'b0;
        #1;
        chk("wr_aw_dropped", {m_awvalid, m_wvalid}, 2'b01);
        chk("wr_awsatp_hold", m_awsatp, 32'h8008_0000);
        tick();
        m_wready = 1'b1;
        #1;
        chk("wr_w_hs", {m_wvalid, m_bready, lsu_bvalid}, 3'b100);
        tick();
        m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; lsu_bready = 1'b0;
        #1;
        chk("wr_b_enter", {lsu_bvalid, m_bready, m_awvalid, m_wvalid}, 4'b1000);
        tick();
        lsu_bready = 1'b1;
        #1;
        chk("wr_b_hs", {lsu_bvalid, m_bready}, 2'b11);
        tick();
        m_bvalid = 1'b0; lsu_bready = 1'b0;
        #1;
        chk("wr_done_idle", {20'd0, vld}, 32'd0);

        // virtual-mode style write: awready/wready/bvalid together
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_1004; lsu_wvalid = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
        #1;
        chk("wr2_grant", {30'd0, lsu_awready, lsu_wready}, 32'h3);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
        #1;
        chk("wr2_same_cycle", {m_awvalid, m_wvalid, lsu_bvalid, m_wstrb}, {3'b110, 4'h3});
        tick();
        m_awready = 1'b0; m_wready = 1'b0; lsu_bready = 1'b1;
        #1;
        chk("wr2_b", {lsu_bvalid, m_bready, m_awvalid, m_wvalid, lsu_bresp}, {4'b1100, 2'b10});
        tick();
        m_bvalid = 1'b0; lsu_bready = 1'b0;

        // read satp latched at grant
        satp = 32'h8008_0000; ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0080;
        #1;
        chk("rsatp_grant", {31'd0, ifu_arready}, 32'h1);
        tick();
        satp = 32'd0; ifu_arvalid = 1'b0;
        #1;
        chk("rsatp_ar0", m_arsatp, 32'h8008_0000);
        tick();
        m_arready = 1'b1;
        #1;
        chk("rsatp_ar1", m_arsatp, 32'h8008_0000);
        tick();
        // reset in RD_R
        m_arready = 1'b0; m_rvalid = 1'b1; ifu_rready = 1'b0; rst = 1'b1;
        #1;
        chk("rst_before", {31'd0, ifu_rvalid}, 32'h1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_after_valids", {20'd0, vld}, 32'd0);
        m_rvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        #1;
        chk("post_rst_grant", {31'd0, ifu_arready}, 32'h1);
        tick();
        ifu_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("post_rst_ar", {31'd0, m_arvalid}, 32'h1);
        chk("post_rst_arsatp", m_arsatp, 32'd0);
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0010_0073; ifu_rready = 1'b1;
        #1;
        chk("post_rst_rdata", ifu_rdata, 32'h0010_0073);
        chk("post_rst_rvalid", {ifu_rvalid, m_rready}, 2'b11);
        tick();
        m_rvalid = 1'b0; ifu_rready = 1'b0;
        #1;
        chk("final_idle", {20'd0, vld}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
